// File: rtl/pipeline_seq_ctrl.sv
// Sequencing controller for the 5-stage pipeline: load-use bubbles, taken-branch
// redirect, fixed data-memory wait states and a saturating stall-cycle counter.
module pipeline_seq_ctrl #(
    parameter int unsigned MEM_WAIT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             ex_load,
    input  logic [3:0]       ex_rd,
    input  logic [3:0]       id_rn,
    input  logic [3:0]       id_rm,
    input  logic             id_rn_used,
    input  logic             id_rm_used,
    input  logic             branch_taken,
    input  logic             mem_access,
    output logic             pc_ld,
    output logic             ifid_ld,
    output logic             pipe_ld,
    output logic             cu_nop_sel,
    output logic             ifid_clr,
    output logic             pc_sel,
    output logic             mem_ready,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_DONE} state_t;

    localparam logic       NO_WAIT   = (MEM_WAIT == 0);
    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    state_t     state, state_nxt;
    logic [3:0] wcnt, wcnt_nxt;
    logic       hazard;

    assign hazard = ex_load & ((id_rn_used & (id_rn == ex_rd)) |
                               (id_rm_used & (id_rm == ex_rd)));

    // State, wait counter and saturating stall counter
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state        <= S_RUN;
            wcnt         <= '0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
            if (!pc_ld && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    // Next state and combinational pipeline controls
    always_comb begin
        state_nxt  = state;
        wcnt_nxt   = wcnt;
        pc_ld      = 1'b1;
        ifid_ld    = 1'b1;
        pipe_ld    = 1'b1;
        cu_nop_sel = 1'b0;
        ifid_clr   = 1'b0;
        pc_sel     = 1'b0;
        mem_ready  = 1'b0;

        if (state == S_WAIT) begin
            pc_ld   = 1'b0;
            ifid_ld = 1'b0;
            pipe_ld = 1'b0;
            // wcnt holds the WAIT cycles still owed, including this one
            if (wcnt <= 4'd1) begin
                state_nxt = S_DONE;
                wcnt_nxt  = '0;
            end else begin
                wcnt_nxt = wcnt - 4'd1;
            end
        end else if ((state == S_RUN) && !NO_WAIT && mem_access) begin
            // The access cycle itself is the first of MEM_WAIT stall cycles
            pc_ld     = 1'b0;
            ifid_ld   = 1'b0;
            pipe_ld   = 1'b0;
            state_nxt = (WAIT_INIT == 4'd0) ? S_DONE : S_WAIT;
            wcnt_nxt  = WAIT_INIT;
        end else begin
            if (state == S_DONE) begin
                mem_ready = 1'b1;
                state_nxt = S_RUN;
            end else begin
                mem_ready = NO_WAIT & mem_access;
            end
            if (hazard) begin
                pc_ld      = 1'b0;
                ifid_ld    = 1'b0;
                cu_nop_sel = 1'b1;
            end else if (branch_taken) begin
                pc_sel   = 1'b1;
                ifid_clr = 1'b1;
            end
        end

        if (CLR) begin
            pc_ld      = 1'b0;
            ifid_ld    = 1'b0;
            pipe_ld    = 1'b0;
            cu_nop_sel = 1'b1;
            ifid_clr   = 1'b1;
            pc_sel     = 1'b0;
            mem_ready  = 1'b0;
        end
    end

endmodule
